fft_pingpong_ram: RTL and testbench
===================================

// Module: fft_pingpong_ram
// PURPOSE
//  Two-bank ping-pong sample buffer for the FFT datapath; successor to the single-bank ram.
//  Producer fills one bank with a frame of NUMADDR words at arbitrary (e.g. bit-reversed)
//  addresses while consumer randomly reads the other; banks swap on frame boundaries.
//  Sits between input sample capture and butterfly stages; one clock domain.
// PARAMETERS
//  WORDSIZE  16  data word width (bits)
//  ADDRSIZE  5   address width; addresses >= NUMADDR are out of range
//  NUMADDR   32  words per bank (frame length), must be <= 2**ADDRSIZE
// PORTS
//  clk       in   1         clock, all logic on posedge
//  rst       in   1         synchronous reset, active-high
//  wr_en     in   1         write strobe
//  wr_addr   in   ADDRSIZE  write address within current write bank
//  wr_data   in   WORDSIZE  write data
//  wr_last   in   1         qualifies wr_en: this write completes the frame
//  wr_ready  out  1         write bank is free (combinational from state regs)
//  rd_en     in   1         read strobe
//  rd_addr   in   ADDRSIZE  read address within current read bank
//  rd_done   in   1         consumer releases current read bank
//  rd_avail  out  1         a full bank is available to read
//  rd_data   out  WORDSIZE  registered read data
//  rd_valid  out  1         rd_data valid this cycle
//  wr_ovf    out  1         sticky: write attempted while !wr_ready
//  rd_udf    out  1         sticky: read/done attempted while !rd_avail
//  addr_err  out  1         sticky: accepted access with address >= NUMADDR
// BEHAVIOUR
//  State: wr_sel, rd_sel (1 bit each), bank_full[1:0]. Reset: all 0; rd_data=0, rd_valid=0,
//   sticky flags=0. Memory contents NOT cleared by reset. Reset mid-frame discards both frames.
//  wr_ready = !bank_full[wr_sel]; rd_avail = bank_full[rd_sel].
//  Write accepted when wr_en & wr_ready & addr<NUMADDR: mem[wr_sel][wr_addr] <= wr_data.
//  Frame close: wr_en & wr_ready & wr_last -> bank_full[wr_sel]<=1, wr_sel toggles next cycle
//   (data write still performed if address valid; out-of-range last write still closes frame).
//  Read: rd_en & rd_avail & addr<NUMADDR -> next cycle rd_data=mem[rd_sel][rd_addr], rd_valid=1.
//   Latency 1 cycle. Otherwise rd_valid=0, rd_data holds previous value.
//  Release: rd_done & rd_avail -> bank_full[rd_sel]<=0, rd_sel toggles next cycle. rd_en in the
//   same cycle as rd_done still reads the released bank (read uses pre-toggle rd_sel).
//  Simultaneous frame close and release in one cycle: both applied; they always target
//   different banks (writer never owns a full bank, reader only owns a full bank).
//  Both banks full: wr_ready=0 until rd_done. Both empty: rd_avail=0 until wr_last.
//  Writes to bank being read are impossible by construction; no read/write collision logic.
//  Rejected accesses (not ready/avail) change no state other than error flags.
// CONFIGURATION
//  PINGPONG_ERR_EN defined: wr_ovf, rd_udf, addr_err implemented as sticky flags, cleared only
//   by rst. Undefined: ports kept, tied 0; address range check still gates accesses.
// TESTING  (WORDSIZE=16, ADDRSIZE=5, NUMADDR=8)
//  1 Write addr 0..7 data FFFF..FFF8, wr_last on addr 7 -> wr_ready stays 1 (bank1 free),
//    rd_avail=1 next cycle; read addr 0..7 -> rd_data FFFF..FFF8 one cycle after each rd_en.
//  2 Fill both banks (bank0 0x0100+i, bank1 0x0200+i) -> wr_ready=0; further wr_en sets wr_ovf,
//    memory unchanged; rd_done -> wr_ready=1 next cycle, rd_avail=1, reads return 0x0200+i.
//  3 Write bank0 then bank1's last word in same cycle as rd_done on bank0 -> next cycle
//    bank_full=2'b10, rd_sel=1, wr_sel=0, wr_ready=1, rd_avail=1.
//  4 rd_en with rd_avail=0 -> rd_valid=0, rd_data unchanged, rd_udf=1; write addr 9 ->
//    no write, addr_err=1; with PINGPONG_ERR_EN undefined all three flags stay 0.
//  5 Assert rst after 4 of 8 writes -> wr_ready=1, rd_avail=0, rd_valid=0, flags 0; new frame
//    of 8 writes then reads returns only new data.

Source files
------------

// File: rtl/fft_pingpong_ram.sv
// Two-bank ping-pong sample buffer: producer fills one bank while the consumer reads the other.
// Optional macro PINGPONG_ERR_EN enables the sticky wr_ovf / rd_udf / addr_err flags.
module fft_pingpong_ram #(
  parameter int unsigned WORDSIZE = 16,
  parameter int unsigned ADDRSIZE = 5,
  parameter int unsigned NUMADDR  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDRSIZE-1:0] wr_addr,
  input  logic [WORDSIZE-1:0] wr_data,
  input  logic                wr_last,
  output logic                wr_ready,
  input  logic                rd_en,
  input  logic [ADDRSIZE-1:0] rd_addr,
  input  logic                rd_done,
  output logic                rd_avail,
  output logic [WORDSIZE-1:0] rd_data,
  output logic                rd_valid,
  output logic                wr_ovf,
  output logic                rd_udf,
  output logic                addr_err
);

  localparam logic [ADDRSIZE:0] NumAddr = NUMADDR[ADDRSIZE:0];

  logic [WORDSIZE-1:0] mem [2][2**ADDRSIZE];
  logic                wr_sel;
  logic                rd_sel;
  logic [1:0]          bank_full;

  logic wr_in_range;
  logic rd_in_range;
  logic wr_acc;
  logic wr_close;
  logic rd_acc;
  logic rd_rel;

  assign wr_ready    = !bank_full[wr_sel];
  assign rd_avail    = bank_full[rd_sel];
  assign wr_in_range = {1'b0, wr_addr} < NumAddr;
  assign rd_in_range = {1'b0, rd_addr} < NumAddr;
  assign wr_acc      = wr_en & wr_ready;
  assign wr_close    = wr_acc & wr_last;
  assign rd_acc      = rd_en & rd_avail & rd_in_range;
  assign rd_rel      = rd_done & rd_avail;

  // Close and release never target the same bank, so both updates can land in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      bank_full <= 2'b00;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rd_sel][rd_addr];
      end
      if (wr_close) begin
        bank_full[wr_sel] <= 1'b1;
        wr_sel            <= ~wr_sel;
      end
      if (rd_rel) begin
        bank_full[rd_sel] <= 1'b0;
        rd_sel            <= ~rd_sel;
      end
    end
  end

  // Storage is intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc && wr_in_range) begin
      mem[wr_sel][wr_addr] <= wr_data;
    end
  end

`ifdef PINGPONG_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ovf   <= 1'b0;
      rd_udf   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (wr_en && !wr_ready) begin
        wr_ovf <= 1'b1;
      end
      if ((rd_en || rd_done) && !rd_avail) begin
        rd_udf <= 1'b1;
      end
      if ((wr_acc && !wr_in_range) || (rd_en && rd_avail && !rd_in_range)) begin
        addr_err <= 1'b1;
      end
    end
  end
`else
  assign wr_ovf   = 1'b0;
  assign rd_udf   = 1'b0;
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Bench for fft_pingpong_ram: directed frame scenarios plus randomized traffic vs a frame-level model.
module tb_fft_pingpong_ram;
  localparam int W = 16;
  localparam int A = 5;
  localparam int N = 8;
`ifdef PINGPONG_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wr_en = 1'b0;
  logic [A-1:0] wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic         wr_last = 1'b0;
  logic         wr_ready;
  logic         rd_en = 1'b0;
  logic [A-1:0] rd_addr = '0;
  logic         rd_done = 1'b0;
  logic         rd_avail;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         wr_ovf;
  logic         rd_udf;
  logic         addr_err;

  always #5 clk = ~clk;

  fft_pingpong_ram #(.WORDSIZE(W), .ADDRSIZE(A), .NUMADDR(N)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done), .rd_avail(rd_avail),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_ovf(wr_ovf), .rd_udf(rd_udf), .addr_err(addr_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each bank holds a frame; a bank is owned by the writer until closed, then by the reader.
  logic [W-1:0] m_mem   [2][32];
  bit           m_known [2][32];
  bit           m_full  [2];
  bit           m_wbank;
  bit           m_rbank;
  logic [W-1:0] m_rdata = '0;
  bit           m_rdata_known = 1'b1;
  bit           m_rvalid;
  bit           m_ovf, m_udf, m_aerr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_apply();
    bit can_wr;
    bit can_rd;
    can_wr = !m_full[m_wbank];
    can_rd = m_full[m_rbank];
    if (rst) begin
      m_full[0] = 0; m_full[1] = 0;
      m_wbank = 0; m_rbank = 0;
      m_rdata = '0; m_rdata_known = 1; m_rvalid = 0;
      m_ovf = 0; m_udf = 0; m_aerr = 0;
      return;
    end
    m_rvalid = 0;
    if (rd_en && can_rd && int'(rd_addr) < N) begin
      m_rdata       = m_mem[m_rbank][rd_addr];
      m_rdata_known = m_known[m_rbank][rd_addr];
      m_rvalid      = 1;
    end
    if (ErrEn) begin
      if (wr_en && !can_wr) m_ovf = 1;
      if ((rd_en || rd_done) && !can_rd) m_udf = 1;
      if ((wr_en && can_wr && int'(wr_addr) >= N) || (rd_en && can_rd && int'(rd_addr) >= N))
        m_aerr = 1;
    end
    if (wr_en && can_wr) begin
      if (int'(wr_addr) < N) begin
        m_mem[m_wbank][wr_addr]   = wr_data;
        m_known[m_wbank][wr_addr] = 1;
      end
      if (wr_last) begin
        m_full[m_wbank] = 1;
        m_wbank = !m_wbank;
      end
    end
    if (rd_done && can_rd) begin
      m_full[m_rbank] = 0;
      m_rbank = !m_rbank;
    end
  endfunction

  task automatic compare_all();
    chk("wr_ready", wr_ready, !m_full[m_wbank]);
    chk("rd_avail", rd_avail, m_full[m_rbank]);
    chk("rd_valid", rd_valid, m_rvalid);
    if (m_rdata_known) chk("rd_data", rd_data, m_rdata);
    chk("wr_ovf", wr_ovf, m_ovf);
    chk("rd_udf", rd_udf, m_udf);
    chk("addr_err", addr_err, m_aerr);
  endtask

  task automatic cycle();
    model_apply();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; wr_last = 0; rd_en = 0; rd_done = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); rst = 0;
  endtask

  task automatic wr(input int addr, input logic [W-1:0] data, input bit last, input bit done);
    idle();
    wr_en = 1; wr_addr = A'(addr); wr_data = data; wr_last = last; rd_done = done;
    cycle();
  endtask

  task automatic rd(input int addr);
    idle();
    rd_en = 1; rd_addr = A'(addr);
    cycle();
  endtask

  task automatic release_bank();
    idle(); rd_done = 1; cycle();
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 32; a++) begin m_mem[b][a] = '0; m_known[b][a] = 0; end
    @(negedge clk);
    do_reset();
    chk("reset wr_ready", wr_ready, 1);
    chk("reset rd_avail", rd_avail, 0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset rd_data", rd_data, 0);

    // Single frame, then read it back
    for (int i = 0; i < N; i++) wr(i, 16'hFFFF - 16'(i), i == N - 1, 0);
    chk("t1 wr_ready", wr_ready, 1);
    chk("t1 rd_avail", rd_avail, 1);
    for (int i = 0; i < N; i++) begin
      rd(i);
      chk("t1 rd_valid", rd_valid, 1);
      chk("t1 rd_data", rd_data, 16'hFFFF - 16'(i));
    end

    // Both banks full, overflow attempt, then release
    do_reset();
    for (int i = 0; i < N; i++) wr(i, 16'h0100 + 16'(i), i == N - 1, 0);
    for (int i = 0; i < N; i++) wr(i, 16'h0200 + 16'(i), i == N - 1, 0);
    chk("t2 wr_ready full", wr_ready, 0);
    wr(0, 16'hDEAD, 0, 0);
    chk("t2 wr_ovf", wr_ovf, ErrEn);
    rd(0);
    chk("t2 bank0 intact", rd_data, 16'h0100);
    release_bank();
    chk("t2 wr_ready after done", wr_ready, 1);
    chk("t2 rd_avail after done", rd_avail, 1);
    for (int i = 0; i < N; i++) begin
      rd(i);
      chk("t2 bank1 data", rd_data, 16'h0200 + 16'(i));
    end

    // Frame close coinciding with release
    do_reset();
    for (int i = 0; i < N; i++) wr(i, 16'h0300 + 16'(i), i == N - 1, 0);
    for (int i = 0; i < N - 1; i++) wr(i, 16'h0400 + 16'(i), 0, 0);
    wr(N - 1, 16'h0407, 1, 1);
    chk("t3 wr_ready", wr_ready, 1);
    chk("t3 rd_avail", rd_avail, 1);
    rd(5);
    chk("t3 read bank1", rd_data, 16'h0405);

    // Underflow and out-of-range address
    do_reset();
    rd(3);
    chk("t4 rd_valid", rd_valid, 0);
    chk("t4 rd_data held", rd_data, 0);
    chk("t4 rd_udf", rd_udf, ErrEn);
    wr(9, 16'h1234, 0, 0);
    chk("t4 addr_err", addr_err, ErrEn);

    // Reset mid-frame discards the partial frame
    do_reset();
    for (int i = 0; i < 4; i++) wr(i, 16'h0500 + 16'(i), 0, 0);
    do_reset();
    chk("t5 wr_ready", wr_ready, 1);
    chk("t5 rd_avail", rd_avail, 0);
    chk("t5 rd_valid", rd_valid, 0);
    chk("t5 flags", {wr_ovf, rd_udf, addr_err}, 0);
    for (int i = 0; i < N; i++) wr(i, 16'h0600 + 16'(i), i == N - 1, 0);
    for (int i = 0; i < N; i++) begin
      rd(i);
      chk("t5 new data", rd_data, 16'h0600 + 16'(i));
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = A'($urandom_range(0, 9));
      wr_data = W'($urandom);
      wr_last = ($urandom_range(0, 7) == 0);
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = A'($urandom_range(0, 9));
      rd_done = ($urandom_range(0, 5) == 0);
      cycle();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
